// File: rtl/gpu_pkg.sv
// Shared constants and state encoding for the buffered custom-instruction front end.
package gpu_pkg;

  localparam logic [3:0]  QUERY_FRAME_OP = 4'hF;
  localparam logic [3:0]  QUERY_LEVEL_OP = 4'hE;
  localparam int unsigned ACCEPT_CODE    = 950;
  localparam int unsigned REJECT_CODE    = 900;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESPOND  = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is always on o_data.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (PTR_W+1)'(1);
        2'b01:   r_level <= r_level - (PTR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_data;
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_level = r_level;

endmodule

// File: rtl/gpu_instruction_buffer.sv
// Custom-instruction front end: decodes one transaction per clk_en rise, answers
// with a status/query code and queues drawing instructions for the control unit.
module gpu_instruction_buffer
  import gpu_pkg::state_t, gpu_pkg::ST_IDLE, gpu_pkg::ST_RESPOND, gpu_pkg::ST_WAIT_REL;
#(
  parameter int                  DEPTH          = 16,
  parameter int                  DATA_W         = 32,
  parameter int                  OPCODE_W       = 4,
  parameter logic [OPCODE_W-1:0] QUERY_FRAME_OP = OPCODE_W'(gpu_pkg::QUERY_FRAME_OP),
  parameter logic [OPCODE_W-1:0] QUERY_LEVEL_OP = OPCODE_W'(gpu_pkg::QUERY_LEVEL_OP),
  parameter int unsigned         ACCEPT_CODE    = gpu_pkg::ACCEPT_CODE,
  parameter int unsigned         REJECT_CODE    = gpu_pkg::REJECT_CODE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic [DATA_W-1:0]        dataA,
  input  logic [DATA_W-1:0]        dataB,
  input  logic                     frame_tick,
  input  logic                     out_ready,
  output logic                     done,
  output logic [DATA_W-1:0]        result,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_dataA,
  output logic [DATA_W-1:0]        out_dataB,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  state_t              r_state;
  state_t              w_nextState;
  logic                r_clkEnPrev;
  logic                w_rise;
  logic                w_start;
  logic                w_push;
  logic                w_reject;
  logic                w_full;
  logic                w_empty;
  logic [31:0]         r_frameCount;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   w_respData;
  logic [OPCODE_W-1:0] w_opcode;
  logic [2*DATA_W-1:0] w_head;
  logic                r_overflow;

  assign w_rise   = clk_en && !r_clkEnPrev;
  assign w_opcode = dataA[OPCODE_W-1:0];

  // Edge-detect copy resets high so a clk_en held across reset is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_clkEnPrev  <= 1'b1;
      r_result     <= '0;
      r_overflow   <= 1'b0;
      r_frameCount <= '0;
    end else begin
      r_state     <= w_nextState;
      r_clkEnPrev <= clk_en;
      if (w_start)    r_result     <= w_respData;
      if (w_reject)   r_overflow   <= 1'b1;
      if (frame_tick) r_frameCount <= r_frameCount + 32'd1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:     if (w_rise) w_nextState = ST_RESPOND;
      ST_RESPOND:  w_nextState = clk_en ? ST_WAIT_REL : ST_IDLE;
      ST_WAIT_REL: if (!clk_en) w_nextState = ST_IDLE;
      default:     w_nextState = ST_IDLE;
    endcase
  end

  // The whole action is decided in the rise cycle; RESPOND only replays it.
  always_comb begin
    w_start    = (r_state == ST_IDLE) && w_rise;
    w_push     = 1'b0;
    w_reject   = 1'b0;
    w_respData = '0;
    if (w_start) begin
      if (w_opcode == QUERY_FRAME_OP) begin
        w_respData = DATA_W'(r_frameCount);
      end else if (w_opcode == QUERY_LEVEL_OP) begin
        w_respData = DATA_W'(level);
      end else if (w_full) begin
        w_reject   = 1'b1;
        w_respData = DATA_W'(REJECT_CODE);
      end else begin
        w_push     = 1'b1;
        w_respData = DATA_W'(ACCEPT_CODE);
      end
    end
    done   = (r_state == ST_RESPOND);
    result = done ? r_result : '0;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (out_ready),
    .i_data  ({dataA, dataB}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign out_valid = !w_empty;
  assign out_dataA = out_valid ? w_head[2*DATA_W-1:DATA_W] : '0;
  assign out_dataB = out_valid ? w_head[DATA_W-1:0] : '0;
  assign overflow  = r_overflow;

endmodule
